motor_clock_divider: RTL and testbench
======================================

# motor_clock_divider

Programmable integer clock divider that consumes the selected clock from the core/IO clock selector and produces the divided step clock for the motor driver channels. The block runs entirely in the selected-clock domain. Divisor updates arrive over a valid/ready handshake and take effect only on a period boundary, so the divided clock never emits runt pulses. A clean stop is guaranteed when the divider is disabled.

## Interface
Parameters:
- WIDTH, 16, divisor and counter width in bits.
- DEFAULT_DIV, 4, divisor in effect after reset; must be >= 2.

Ports:
- clock  in  1  selected clock from the clock selector; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state without a clock edge.
- enable  in  1  run request for the divided clock.
- div_data  in  WIDTH  requested divisor N, the period in clock cycles.
- div_valid  in  1  div_data is valid; must be held with stable data until div_ready is seen.
- div_ready  out  1  high when the pending-update register is empty.
- clk_div  out  1  divided clock, driven from a register.
- tick  out  1  one-cycle pulse in the first cycle of every divided period.
- active_div  out  WIDTH  divisor currently in effect, after clamping.

## Operation
- Reset values: clk_div=0, tick=0, div_ready=1, active_div=DEFAULT_DIV, cnt=0, pending empty, state=IDLE.
- Clamping: a captured N < 2 is stored as 2. active_div always reports the clamped value.
- Period shape for N: the period counter cnt runs 0..N-1.
  - clk_div=1 while cnt < ceil(N/2).
  - clk_div=0 for the remaining floor(N/2) cycles.
  - tick=1 exactly when cnt==0.
- States:
  - IDLE: cnt=0, clk_div=0, tick=0. Moves to RUN when enable is sampled high.
  - RUN: cnt increments and wraps from N-1 to 0. Moves to DRAIN when enable is sampled low.
  - DRAIN: continues the current period unchanged. Moves to IDLE after the cnt==N-1 cycle. If enable is sampled high again before that, returns to RUN with no disturbance to the waveform.
- Handshake:
  - Capture into pending on any edge where div_valid && div_ready. div_ready goes low on the next cycle.
  - Pending is applied at the first terminal cycle (cnt==N-1 in RUN or DRAIN) strictly after the capture edge. In IDLE it is applied on the edge after capture.
  - On apply, active_div updates, the new period starts at cnt=0, and div_ready returns high on the same edge.
  - A capture coinciding with a terminal cycle waits for the next terminal cycle.
- Simultaneous apply and enter-IDLE (DRAIN terminal cycle): the update is applied and the block enters IDLE. The next run uses the new divisor.
- Arithmetic: cnt is WIDTH bits. The terminal compare is against active_div-1. No overflow is possible because active_div is at least 2.

## Timing
- Start latency: enable sampled high at edge t in IDLE gives clk_div=1, tick=1, cnt=0 after edge t.
- Stop: clk_div falls to 0 no later than the end of the current period. The last period is always complete.
- Update latency: at most N cycles plus 1 cycle from capture to the new period, with N the old divisor.
- All outputs are registered; there is no combinational path from any input to any output.
- Asynchronous reset mid-operation: outputs take their reset values immediately, and any pending update is discarded.

## Test plan
- Reset, then enable with the default divisor: clk_div = 1100 repeating, tick on every 4th cycle aligned with the rising edge of clk_div, active_div=4.
- While running at N=4, send div_data=5 at cnt=1:
  - div_ready stays low until the cnt==3 edge.
  - The next period is 11100 and active_div=5.
- Send N=0, then N=1: each is clamped and active_div=2. clk_div = 10 repeating with tick every cycle of the high phase.
- N=6, drop enable at cnt=1:
  - The full 111000 period completes, then the block goes IDLE with clk_div=0.
  - Re-enabling gives tick=1 and cnt=0 one edge later.
- Assert reset during the high phase: clk_div=0, tick=0, div_ready=1 and active_div=4 with no clock edge. A pending N=9 is discarded.
- Hold div_valid with N=7 while div_ready is low from a prior N=3 capture: N=3 is applied first, then N=7 is captured on the ready edge and applied at the next terminal cycle. No value is lost or duplicated.

Source files
------------

// File: rtl/motor_clock_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : motor_clock_divider
//  Purpose  : Glitch-free programmable integer divider producing the motor step
//             clock; divisor updates land only on period boundaries.
//  Revision : 1.0
// ============================================================================
module motor_clock_divider #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_data,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_div,
    output logic             tick,
    output logic [WIDTH-1:0] active_div
);

    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] C_DEFAULT = (DEFAULT_DIV < 2) ? C_MIN_DIV : WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;

    logic             w_terminal;
    logic             w_capture;
    logic             w_apply;
    logic [WIDTH-1:0] w_high_len;

    always_comb begin
        w_terminal  = (state_q != S_IDLE) && (cnt_q == (active_q - C_ONE));
        w_capture   = div_valid && !pend_full_q;
        w_apply     = pend_full_q && ((state_q == S_IDLE) || w_terminal);

        state_d     = state_q;
        cnt_d       = cnt_q;
        active_d    = w_apply ? pend_q : active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        if (w_capture) begin
            pend_d      = (div_data < C_MIN_DIV) ? C_MIN_DIV : div_data;
            pend_full_d = 1'b1;
        end else if (w_apply) begin
            pend_full_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                // Enable dropping on the last cycle already completes the period.
                if (!enable) state_d = w_terminal ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (enable)          state_d = S_RUN;
                else if (w_terminal) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE || state_q == S_IDLE || w_terminal) cnt_d = '0;
        else                                                      cnt_d = cnt_q + C_ONE;

        // High phase is ceil(N/2), written to avoid overflow of N+1.
        w_high_len = active_d - (active_d >> 1);
        clk_div_d  = (state_d != S_IDLE) && (cnt_d < w_high_len);
        tick_d     = (state_d != S_IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            active_q    <= C_DEFAULT;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            clk_div_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            clk_div_q   <= clk_div_d;
            tick_q      <= tick_d;
        end
    end

    assign div_ready  = !pend_full_q;
    assign clk_div    = clk_div_q;
    assign tick       = tick_q;
    assign active_div = active_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_clock_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_motor_clock_divider
//  Purpose  : Directed scoreboard bench for motor_clock_divider.
//  Revision : 1.0
// ============================================================================
module tb_motor_clock_divider;

    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] div_data;
    logic             div_valid;
    logic             div_ready;
    logic             clk_div;
    logic             tick;
    logic [WIDTH-1:0] active_div;

    motor_clock_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .div_data   (div_data),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .clk_div    (clk_div),
        .tick       (tick),
        .active_div (active_div)
    );

    typedef struct {
        int cyc;
        bit c;
        bit t;
        int a;
        bit r;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Monitor: compares every expectation tagged for the current cycle.
    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc != cyc) begin
                chk("stale_entry", e.cyc, cyc);
            end else begin
                chk("clk_div",    int'(clk_div),    int'(e.c));
                chk("tick",       int'(tick),       int'(e.t));
                chk("active_div", int'(active_div), e.a);
                chk("div_ready",  int'(div_ready),  int'(e.r));
            end
        end
    end

    task automatic expect_now(input bit c, input bit t, input int a, input bit r);
        exp_t e;
        e.cyc = cyc; e.c = c; e.t = t; e.a = a; e.r = r;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One clock per character; expected levels given as '0'/'1' strings.
    task automatic run_pat(input string cp, input string tp, input int act, input string rp);
        for (int i = 0; i < cp.len(); i++) begin
            step();
            expect_now(cp[i] == "1", tp[i] == "1", act, rp[i] == "1");
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        div_valid = 1'b0;
        div_data  = '0;

        step(); step();
        expect_now(0, 0, 4, 1);
        reset = 1'b0;
        run_pat("0", "0", 4, "1");

        // Default divisor: 1100 repeating.
        enable = 1'b1;
        run_pat("110011001100", "100010001000", 4, "111111111111");

        // Update to 5 requested at cnt=1.
        run_pat("11", "10", 4, "11");
        div_valid = 1'b1; div_data = 16'd5;
        run_pat("0", "0", 4, "0");
        div_valid = 1'b0;
        run_pat("0", "0", 4, "0");
        run_pat("1110011100", "1000010000", 5, "1111111111");

        // N=0 captured on a terminal cycle: waits a full period, clamps to 2.
        div_valid = 1'b1; div_data = 16'd0;
        run_pat("1", "1", 5, "0");
        div_valid = 1'b0;
        run_pat("1100", "0000", 5, "0000");
        run_pat("1", "1", 2, "1");
        div_valid = 1'b1; div_data = 16'd1;
        run_pat("0", "0", 2, "0");
        div_valid = 1'b0;
        run_pat("101010", "101010", 2, "111111");

        // N=6, then drop enable at cnt=1 and drain.
        div_valid = 1'b1; div_data = 16'd6;
        run_pat("1", "1", 2, "0");
        div_valid = 1'b0;
        run_pat("0", "0", 2, "0");
        run_pat("11100011", "10000010", 6, "11111111");
        enable = 1'b0;
        run_pat("1000", "0000", 6, "1111");
        run_pat("000", "000", 6, "111");
        enable = 1'b1;
        run_pat("11", "10", 6, "11");

        // Capture N=9, then reset asynchronously during the high phase.
        div_valid = 1'b1; div_data = 16'd9;
        run_pat("1", "0", 6, "0");
        div_valid = 1'b0;
        @(negedge clock);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("rst_clk_div",    int'(clk_div),    0);
        chk("rst_tick",       int'(tick),       0);
        chk("rst_div_ready",  int'(div_ready),  1);
        chk("rst_active_div", int'(active_div), 4);
        step();
        reset = 1'b0;
        run_pat("0", "0", 4, "1");
        enable = 1'b1;
        run_pat("11001100", "10001000", 4, "11111111");

        // N=3 on a terminal cycle, then N=7 held until ready returns.
        div_valid = 1'b1; div_data = 16'd3;
        run_pat("1", "1", 4, "0");
        div_data = 16'd7;
        run_pat("100", "000", 4, "000");
        run_pat("1", "1", 3, "1");
        run_pat("1", "0", 3, "0");
        div_valid = 1'b0;
        run_pat("0", "0", 3, "0");
        run_pat("11110001111000", "10000001000000", 7, "11111111111111");

        @(negedge clock);
        #1;
        if (sb_q.size() != 0) chk("scoreboard_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
